bcd_xs3_codec: RTL and testbench

BCD_XS3_CODEC -- requirements
Module: bcd_xs3_codec

---
 rtl/bcd_xs3_codec.sv | 77 +++++++
 tb/tb_bcd_xs3_codec.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bcd_xs3_codec.sv
// bcd_xs3_codec: per-digit BCD <-> Excess-3 converter, one digit per cycle, valid/ready handshake
module bcd_xs3_codec #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mode,
  input  logic [4*DIGITS-1:0] din,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] dout,
  output logic [DIGITS-1:0]   err_mask,
  output logic                err
);
  localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t              state;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] src, res, res_n;
  logic [DIGITS-1:0]   emask, emask_n;
  logic                mode_r, bad, last;
  logic [3:0]          cur, val;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign last      = cnt == CW'(DIGITS - 1);
  // convert the digit selected by the counter and merge it into the partial result
  always_comb begin
    cur = '0;
    res_n = res;
    emask_n = emask;
    for (int i = 0; i < DIGITS; i++) if (cnt == CW'(i)) cur = src[4*i +: 4];
    bad = mode_r ? (cur < 4'd3 || cur > 4'd12) : cur > 4'd9;
    val = bad ? 4'h0 : mode_r ? cur - 4'd3 : cur + 4'd3;
    for (int i = 0; i < DIGITS; i++) if (cnt == CW'(i)) begin
      res_n[4*i +: 4] = val;
      emask_n[i] = bad;
    end
  end
  // control FSM; outputs change only on the final conversion step
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      src <= '0;
      res <= '0;
      emask <= '0;
      mode_r <= 1'b0;
      dout <= '0;
      err_mask <= '0;
      err <= 1'b0;
    end else case (state)
      IDLE: if (in_valid) begin
        src <= din;
        mode_r <= mode;
        cnt <= '0;
        res <= '0;
        emask <= '0;
        state <= CONV;
      end
      CONV: begin
        res <= res_n;
        emask <= emask_n;
        cnt <= cnt + CW'(1);
        if (last) begin
          dout <= res_n;
          err_mask <= emask_n;
          err <= |emask_n;
          state <= DONE;
        end
      end
      DONE: if (out_ready) state <= IDLE;
      default: state <= IDLE;
    endcase
  end
endmodule

// File: tb/tb_bcd_xs3_codec.sv
// tb_bcd_xs3_codec: scoreboard bench driving DIGITS=4, 1 and 8 instances
module tb_bcd_xs3_codec;
  typedef struct {
    int          id;
    int          acc;
    logic [31:0] d;
    logic [7:0]  m;
    logic        e;
  } exp_t;
  logic        clk = 0, rst = 1, mode = 0, out_ready = 1;
  logic [31:0] din = '0;
  logic        iv[3] = '{0, 0, 0};
  logic        pov[3] = '{0, 0, 0};
  logic        ir[3], ov[3], er[3];
  logic [31:0] dv[3];
  logic [7:0]  mk[3];
  logic [15:0] d4;
  logic [3:0]  m4, d1;
  logic        m1;
  logic [31:0] d8;
  logic [7:0]  m8;
  exp_t        q[$];
  int          cyc = 0, n_pass = 0, n_tot = 0;
  int          lat[3] = '{4, 1, 8};
  logic [63:0] x_tab = 64'h000000CBA9876543, b_tab = 64'h0009876543210000;
  logic [15:0] x_err = 16'hFC00, b_err = 16'hE007;

  bcd_xs3_codec #(.DIGITS(4)) u4 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .mode(mode),
    .din(din[15:0]), .out_valid(ov[0]), .out_ready(out_ready), .dout(d4), .err_mask(m4), .err(er[0]));
  bcd_xs3_codec #(.DIGITS(1)) u1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .mode(mode),
    .din(din[3:0]), .out_valid(ov[1]), .out_ready(out_ready), .dout(d1), .err_mask(m1), .err(er[1]));
  bcd_xs3_codec #(.DIGITS(8)) u8 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .mode(mode),
    .din(din), .out_valid(ov[2]), .out_ready(out_ready), .dout(d8), .err_mask(m8), .err(er[2]));
  assign dv[0] = {16'h0, d4};
  assign dv[1] = {28'h0, d1};
  assign dv[2] = d8;
  assign mk[0] = {4'h0, m4};
  assign mk[1] = {7'h0, m1};
  assign mk[2] = m8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic send(int k, logic m, logic [31:0] d, logic [31:0] ed, logic [7:0] em);
    chk("ready before send", ir[k], 1);
    din = d;
    mode = m;
    iv[k] = 1;
    q.push_back('{id: k, acc: cyc + 1, d: ed, m: em, e: |em});
    step;
    iv[k] = 0;
    din = ~d;
    mode = ~m;
  endtask

  task automatic wait_done;
    for (int i = 0; i < 200 && q.size() != 0; i++) step;
    if (q.size() != 0) begin
      n_tot++;
      $display("FAIL timeout: %0d words pending, required 0", q.size());
      q.delete();
    end
    step;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ov[k] && !pov[k]) begin
        if (q.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected output: dut %0d dout %h, required no output", k, dv[k]);
        end else begin
          chk("latency", cyc - q[0].acc, lat[k]);
          chk("dut id", k, q[0].id);
        end
      end
      if (ov[k] && out_ready && q.size() != 0) begin
        chk("dout", dv[k], q[0].d);
        chk("err_mask", {24'h0, mk[k]}, {24'h0, q[0].m});
        chk("err", {31'h0, er[k]}, {31'h0, q[0].e});
        void'(q.pop_front());
      end
      pov[k] = ov[k];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [3:0]  dg;
    logic        eb;
    logic [63:0] tab;
    logic [15:0] etab;
    repeat (3) step;
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      chk("reset in_ready", ir[k], 1);
      chk("reset out_valid", ov[k], 0);
      chk("reset dout", dv[k], 0);
      chk("reset err_mask", {24'h0, mk[k]}, 0);
      chk("reset err", er[k], 0);
    end
    send(0, 0, 32'h0129, 32'h345C, 8'h0); wait_done;
    chk("idle hold dout", dv[0], 32'h345C);
    chk("idle out_valid", ov[0], 0);
    send(0, 1, 32'h345C, 32'h0129, 8'h0); wait_done;
    send(0, 0, 32'h00A5, 32'h3308, 8'h02); wait_done;
    send(0, 1, 32'hD3F4, 32'h0001, 8'h0A); wait_done;
    out_ready = 0;
    send(0, 0, 32'h0129, 32'h345C, 8'h0);
    for (int i = 0; i < 20 && !ov[0]; i++) step;
    chk("bp out_valid rises", ov[0], 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid held", ov[0], 1);
      chk("bp in_ready low", ir[0], 0);
      chk("bp dout held", dv[0], 32'h345C);
      iv[0] = (i == 2);
      din = 32'h9999_9999;
      step;
    end
    iv[0] = 0;
    out_ready = 1;
    step;
    chk("bp release in_ready", ir[0], 1);
    chk("bp release out_valid", ov[0], 0);
    step;
    send(0, 0, 32'h0129, 32'h345C, 8'h0);
    step;
    rst = 1;
    step;
    rst = 0;
    q.delete();
    chk("abort in_ready", ir[0], 1);
    chk("abort out_valid", ov[0], 0);
    chk("abort dout", dv[0], 0);
    chk("abort err", er[0], 0);
    repeat (12) step;
    chk("abort no output", ov[0], 0);
    for (int m = 0; m < 2; m++) begin
      tab = m ? b_tab : x_tab;
      etab = m ? b_err : x_err;
      for (int v = 0; v < 16; v++) begin
        dg = tab[4*v +: 4];
        eb = etab[v];
        send(1, m[0], {28'h0, 4'(v)}, {28'h0, dg}, {7'h0, eb}); wait_done;
        send(2, m[0], {8{4'(v)}}, {8{dg}}, {8{eb}}); wait_done;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
